// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser and per-key debounce with press/release strobes.
// Optional auto-repeat of key_press while a key is held, enabled by the KEY_REPEAT_EN macro.
module key_debounce #(
  parameter int KEY_W           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] keyin,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic             key_any
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("key_debounce: illegal parameter value");
  end

  logic [KEY_W-1:0] s1_r;
  logic [KEY_W-1:0] s2_r;
  logic [CW-1:0]    cnt_r     [KEY_W];
  logic [CW-1:0]    cnt_nxt_s [KEY_W];
  logic [KEY_W-1:0] accept_s;
  logic [KEY_W-1:0] rep_hit_s;

  // two-flop synchroniser for the asynchronous key inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_r <= '0;
      s2_r <= '0;
    end else begin
      s1_r <= keyin;
      s2_r <= s1_r;
    end
  end

  // debounce counter next state; accept when a differing level survives the full count
  always_comb begin
    cnt_nxt_s = '{default: '0};
    accept_s  = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (s2_r[i] == key_level[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == CNT_MAX) begin
        cnt_nxt_s[i] = '0;
        accept_s[i]  = 1'b1;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CW'(1);
      end
    end
  end

  // debounce state, accepted level and one-cycle strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KEY_W; i++) begin
        cnt_r[i] <= '0;
      end
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      for (int i = 0; i < KEY_W; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      key_level   <= (key_level & ~accept_s) | (s2_r & accept_s);
      key_press   <= (accept_s & s2_r) | rep_hit_s;
      key_release <= accept_s & ~s2_r;
    end
  end

  assign key_any = |key_level;

`ifdef KEY_REPEAT_EN
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] RDLY_MAX = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPER_MAX = RW'(REPEAT_PERIOD - 1);

  logic [0:0]       st_r   [KEY_W];
  logic [RW-1:0]    rcnt_r [KEY_W];
  logic [KEY_W-1:0] first_r;

  // repeat hit; a release accepted on the same edge suppresses it
  always_comb begin
    rep_hit_s = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (st_r[i] == ST_HOLD && !accept_s[i]) begin
        rep_hit_s[i] = first_r[i] ? (rcnt_r[i] == RDLY_MAX) : (rcnt_r[i] == RPER_MAX);
      end else begin
        rep_hit_s[i] = 1'b0;
      end
    end
  end

  // per-key IDLE/HOLD state machine with repeat interval counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KEY_W; i++) begin
        st_r[i]   <= ST_IDLE;
        rcnt_r[i] <= '0;
      end
      first_r <= '0;
    end else begin
      for (int i = 0; i < KEY_W; i++) begin
        case (st_r[i])
          ST_IDLE: begin
            if (accept_s[i] && s2_r[i]) begin
              st_r[i]    <= ST_HOLD;
              rcnt_r[i]  <= '0;
              first_r[i] <= 1'b1;
            end
          end
          ST_HOLD: begin
            if (accept_s[i]) begin
              st_r[i]   <= ST_IDLE;
              rcnt_r[i] <= '0;
            end else if (rep_hit_s[i]) begin
              rcnt_r[i]  <= '0;
              first_r[i] <= 1'b0;
            end else begin
              rcnt_r[i] <= rcnt_r[i] + RW'(1);
            end
          end
          default: begin
            st_r[i]   <= ST_IDLE;
            rcnt_r[i] <= '0;
          end
        endcase
      end
    end
  end
`else
  assign rep_hit_s = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: each task queues expected strobe events,
// a negedge monitor pops and checks them; tasks also check levels inline.
module tb_key_debounce;

  localparam int D   = 8;
  localparam int RD  = 20;
  localparam int RP  = 6;
  localparam int LAT = D + 2;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lvl;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] keyin;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic       key_any;

  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;
  ev_t sb[$];

  key_debounce #(
    .KEY_W(4), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .keyin(keyin), .key_level(key_level),
    .key_press(key_press), .key_release(key_release), .key_any(key_any)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // strobe monitor: every strobe must match the next queued expectation
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if ((key_press | key_release) != 4'h0) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe cyc=%0d press=%h release=%h level=%h",
                   cyc, key_press, key_release, key_level);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.press !== key_press || e.rel !== key_release || e.lvl !== key_level) begin
            bad++;
            $display("FAIL strobe got cyc=%0d press=%h release=%h level=%h, exp cyc=%0d press=%h release=%h level=%h",
                     cyc, key_press, key_release, key_level, e.cyc, e.press, e.rel, e.lvl);
          end
        end
      end
    end
  end

  task automatic test_reset();
    int c0;
    rst = 1'b0;
    keyin = 4'hF;
    repeat (2) @(negedge clk);
    total++;
    if ({key_level, key_press, key_release, key_any} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {key_level, key_press, key_release, key_any});
    end
    rst = 1'b1;
    c0 = cyc;
    sb.push_back('{cyc: c0 + LAT, press: 4'hF, rel: 4'h0, lvl: 4'hF});
    repeat (LAT - 1) @(negedge clk);
    total++;
    if (key_level !== 4'h0) begin
      bad++;
      $display("FAIL reset_early_level got=%h exp=0", key_level);
    end
    @(negedge clk);
    total++;
    if (key_level !== 4'hF || key_any !== 1'b1) begin
      bad++;
      $display("FAIL reset_accept got level=%h any=%b exp level=f any=1", key_level, key_any);
    end
    keyin = 4'h0;
    c0 = cyc;
    sb.push_back('{cyc: c0 + LAT, press: 4'h0, rel: 4'hF, lvl: 4'h0});
    repeat (LAT + 2) @(negedge clk);
    total++;
    if (sb.size() != 0 || key_any !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got pending=%0d any=%b exp pending=0 any=0", sb.size(), key_any);
    end
  endtask

  task automatic test_clean();
    int c0;
    keyin = 4'h1;
    c0 = cyc;
    sb.push_back('{cyc: c0 + LAT, press: 4'h1, rel: 4'h0, lvl: 4'h1});
    repeat (20) @(negedge clk);
    total++;
    if (key_level !== 4'h1 || sb.size() != 0) begin
      bad++;
      $display("FAIL clean_press got level=%h pending=%0d exp level=1 pending=0", key_level, sb.size());
    end
    keyin = 4'h0;
    c0 = cyc;
    sb.push_back('{cyc: c0 + LAT, press: 4'h0, rel: 4'h1, lvl: 4'h0});
    repeat (LAT + 4) @(negedge clk);
    total++;
    if (key_level !== 4'h0 || sb.size() != 0) begin
      bad++;
      $display("FAIL clean_release got level=%h pending=%0d exp level=0 pending=0", key_level, sb.size());
    end
  endtask

  task automatic test_bounce();
    int c0;
    for (int k = 0; k < 10; k++) begin
      keyin = (k % 2 == 0) ? 4'h2 : 4'h0;
      repeat (3) @(negedge clk);
    end
    total++;
    if (key_level !== 4'h0) begin
      bad++;
      $display("FAIL bounce_level got=%h exp=0", key_level);
    end
    keyin = 4'h2;
    c0 = cyc;
    sb.push_back('{cyc: c0 + LAT, press: 4'h2, rel: 4'h0, lvl: 4'h2});
    repeat (LAT + 4) @(negedge clk);
    total++;
    if (key_level !== 4'h2 || sb.size() != 0) begin
      bad++;
      $display("FAIL bounce_settle got level=%h pending=%0d exp level=2 pending=0", key_level, sb.size());
    end
    keyin = 4'h0;
    c0 = cyc;
    sb.push_back('{cyc: c0 + LAT, press: 4'h0, rel: 4'h2, lvl: 4'h0});
    repeat (LAT + 2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL bounce_release got pending=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_glitch();
    int c0;
    keyin = 4'h4;
    repeat (D - 1) @(negedge clk);
    keyin = 4'h0;
    repeat (LAT + 2) @(negedge clk);
    total++;
    if (key_level !== 4'h0) begin
      bad++;
      $display("FAIL glitch_level got=%h exp=0", key_level);
    end
    // a fresh press must take the full latency, proving the count was cleared
    keyin = 4'h4;
    c0 = cyc;
    sb.push_back('{cyc: c0 + LAT, press: 4'h4, rel: 4'h0, lvl: 4'h4});
    repeat (LAT + 4) @(negedge clk);
    total++;
    if (key_level !== 4'h4 || sb.size() != 0) begin
      bad++;
      $display("FAIL glitch_repress got level=%h pending=%0d exp level=4 pending=0", key_level, sb.size());
    end
    keyin = 4'h0;
    c0 = cyc;
    sb.push_back('{cyc: c0 + LAT, press: 4'h0, rel: 4'h4, lvl: 4'h0});
    repeat (LAT + 2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL glitch_release got pending=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_mid_reset();
    int c0;
    keyin = 4'h8;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({key_level, key_press, key_release} !== 12'd0) begin
      bad++;
      $display("FAIL midreset_outputs got=%h exp=0", {key_level, key_press, key_release});
    end
    rst = 1'b1;
    c0 = cyc;
    sb.push_back('{cyc: c0 + LAT, press: 4'h8, rel: 4'h0, lvl: 4'h8});
    repeat (LAT + 4) @(negedge clk);
    total++;
    if (key_level !== 4'h8 || sb.size() != 0) begin
      bad++;
      $display("FAIL midreset_restart got level=%h pending=%0d exp level=8 pending=0", key_level, sb.size());
    end
    keyin = 4'h0;
    c0 = cyc;
    sb.push_back('{cyc: c0 + LAT, press: 4'h0, rel: 4'h8, lvl: 4'h0});
    repeat (LAT + 2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL midreset_release got pending=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_simultaneous();
    int c0;
    keyin = 4'h5;
    c0 = cyc;
    sb.push_back('{cyc: c0 + LAT, press: 4'h5, rel: 4'h0, lvl: 4'h5});
    repeat (LAT + 4) @(negedge clk);
    total++;
    if (key_level !== 4'h5 || key_any !== 1'b1) begin
      bad++;
      $display("FAIL simul_press got level=%h any=%b exp level=5 any=1", key_level, key_any);
    end
    keyin = 4'h0;
    c0 = cyc;
    sb.push_back('{cyc: c0 + LAT, press: 4'h0, rel: 4'h5, lvl: 4'h0});
    repeat (LAT + 2) @(negedge clk);
    total++;
    if (sb.size() != 0 || key_any !== 1'b0) begin
      bad++;
      $display("FAIL simul_release got pending=%0d any=%b exp pending=0 any=0", sb.size(), key_any);
    end
  endtask

  task automatic test_repeat();
    int a;
    keyin = 4'h1;
    a = cyc + LAT;
    sb.push_back('{cyc: a, press: 4'h1, rel: 4'h0, lvl: 4'h1});
`ifdef KEY_REPEAT_EN
    for (int t = RD; t <= 50; t += RP) begin
      sb.push_back('{cyc: a + t, press: 4'h1, rel: 4'h0, lvl: 4'h1});
    end
`endif
    repeat (LAT + 44) @(negedge clk);
    keyin = 4'h0;
    sb.push_back('{cyc: a + 44 + LAT, press: 4'h0, rel: 4'h1, lvl: 4'h0});
    repeat (40) @(negedge clk);
    total++;
    if (sb.size() != 0 || key_level !== 4'h0) begin
      bad++;
      $display("FAIL repeat_hold got pending=%0d level=%h exp pending=0 level=0", sb.size(), key_level);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_glitch();
    test_mid_reset();
    test_simultaneous();
    test_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
